// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: ramped PWM H-bridge drive with zero-crossing dead-time on wheel reversal
module motor_drive_ctrl #(
  parameter int PWM_PERIOD   = 2500,
  parameter int CRUISE_DUTY  = 1500,
  parameter int TURN_DUTY    = 1000,
  parameter int RAMP_STEP    = 50,
  parameter int DEAD_PERIODS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] direction,
  output logic       left_in1,
  output logic       left_in2,
  output logic       right_in1,
  output logic       right_in2,
  output logic       settled
);
  localparam int W  = $clog2(PWM_PERIOD + 1);
  localparam int DW = DEAD_PERIODS > 2 ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [W-1:0]  LAST   = W'(PWM_PERIOD - 1);
  localparam logic [W-1:0]  CRUISE = W'(CRUISE_DUTY);
  localparam logic [W-1:0]  TURN   = W'(TURN_DUTY);
  localparam logic [W-1:0]  STEP   = W'(RAMP_STEP);
  localparam logic [DW-1:0] DLOAD  = DW'(DEAD_PERIODS - 1);

  typedef enum logic [1:0] {RUN, DECEL, DEAD} state_t;

  logic [3:0]          dir_q;
  logic [W-1:0]        cnt, tmag;
  logic [1:0][W-1:0]   duty, ramp, fall;
  logic [1:0][DW-1:0]  dcnt;
  logic [1:0]          sign, tsign, keep, ok;
  state_t              state [2];
  logic                boundary, fwd, bwd, trn, trb;

  // index 0 is the left wheel, index 1 the right wheel
  always_comb begin
    fwd = dir_q == 4'd1 || dir_q == 4'd3 || dir_q == 4'd7;
    bwd = dir_q == 4'd5;
    trn = dir_q == 4'd2;
    trb = dir_q == 4'd6;
    tmag = (fwd || bwd) ? CRUISE : (trn || trb) ? TURN : '0;
    tsign = {bwd | trn, bwd | trb};
    boundary = cnt == LAST;
    for (int i = 0; i < 2; i++) begin
      ramp[i] = tmag > duty[i] ? (tmag - duty[i] > STEP ? duty[i] + STEP : tmag)
                               : (duty[i] - tmag > STEP ? duty[i] - STEP : tmag);
      fall[i] = duty[i] > STEP ? duty[i] - STEP : '0;
      keep[i] = tsign[i] == sign[i] || tmag == '0;
      ok[i]   = state[i] == RUN && duty[i] == tmag && keep[i];
    end
  end

  // RUN and DECEL share one rule: ramp when the sign agrees, otherwise brake toward DEAD
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q <= '0;
      cnt <= '0;
      duty <= '0;
      sign <= '0;
      dcnt <= '0;
      for (int i = 0; i < 2; i++) state[i] <= RUN;
      {left_in1, left_in2, right_in1, right_in2} <= '0;
      settled <= 1'b1;
    end else begin
      dir_q <= direction;
      cnt <= boundary ? '0 : cnt + 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (boundary && state[i] == DEAD) begin
          state[i] <= dcnt[i] == '0 ? RUN : DEAD;
          sign[i] <= dcnt[i] == '0 ? tsign[i] : sign[i];
          dcnt[i] <= dcnt[i] == '0 ? '0 : dcnt[i] - 1'b1;
        end else if (boundary) begin
          duty[i] <= keep[i] ? ramp[i] : fall[i];
          state[i] <= keep[i] ? RUN : (fall[i] == '0 ? DEAD : DECEL);
          dcnt[i] <= DLOAD;
        end
      end
      left_in1 <= cnt < duty[0] && !sign[0];
      left_in2 <= cnt < duty[0] && sign[0];
      right_in1 <= cnt < duty[1] && !sign[1];
      right_in2 <= cnt < duty[1] && sign[1];
      settled <= &ok;
    end
  end
endmodule

// File: tb/tb_motor_drive_ctrl.sv
// tb_motor_drive_ctrl: per-period scoreboard of pin high-counts, overlap and settled
module tb_motor_drive_ctrl;
  localparam int P = 100;

  typedef struct packed {
    logic [7:0] l1, l2, r1, r2;
    logic       s, ov;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] direction = 4'd0;
  logic       left_in1, left_in2, right_in1, right_in2, settled;
  int         pc;
  int         vectors = 0;
  int         miscompares = 0;
  obs_t       exp_q[$];

  motor_drive_ctrl #(
    .PWM_PERIOD(P), .CRUISE_DUTY(60), .TURN_DUTY(40), .RAMP_STEP(10), .DEAD_PERIODS(4)
  ) dut (
    .clk(clk), .reset(reset), .direction(direction),
    .left_in1(left_in1), .left_in2(left_in2),
    .right_in1(right_in1), .right_in2(right_in2),
    .settled(settled)
  );

  always #5 clk = ~clk;

  // bench view of the PWM counter; pins seen while pc == c reflect counter value c-1
  always_ff @(posedge clk) pc <= reset ? 0 : (pc == P - 1 ? 0 : pc + 1);

  function automatic obs_t mk(input int l, input int r, input bit s);
    obs_t o;
    o.l1 = 8'(l > 0 ? l : 0);
    o.l2 = 8'(l < 0 ? -l : 0);
    o.r1 = 8'(r > 0 ? r : 0);
    o.r2 = 8'(r < 0 ? -r : 0);
    o.s = s;
    o.ov = 1'b0;
    return o;
  endfunction

  task automatic wait_pc(input int v);
    do @(negedge clk); while (pc != v);
  endtask

  // l/r: signed duty expected during this period (negative = reverse)
  task automatic win(input logic [3:0] d, input int l, input int r, input bit s);
    wait_pc(5);
    direction = d;
    exp_q.push_back(mk(l, r, s));
  endtask

  task automatic check_pins(input string name);
    vectors++;
    if ({left_in1, left_in2, right_in1, right_in2, settled} !== 5'b00001) begin
      miscompares++;
      $display("FAIL %s: got pins=%b settled=%b, want pins=0000 settled=1", name,
               {left_in1, left_in2, right_in1, right_in2}, settled);
    end
  endtask

  initial begin
    int a1, a2, b1, b2, n;
    logic ov, sm, armed;
    obs_t act, e;
    a1 = 0; a2 = 0; b1 = 0; b2 = 0; n = 0;
    ov = 1'b0; sm = 1'b0; armed = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) armed = 1'b0;
      else begin
        if (pc == 1) begin
          a1 = 0; a2 = 0; b1 = 0; b2 = 0; ov = 1'b0; armed = 1'b1;
        end
        a1 += int'(left_in1);
        a2 += int'(left_in2);
        b1 += int'(right_in1);
        b2 += int'(right_in2);
        ov |= (left_in1 & left_in2) | (right_in1 & right_in2);
        if (pc == P / 2) sm = settled;
        if (pc == 0 && armed) begin
          act = '{l1: 8'(a1), l2: 8'(a2), r1: 8'(b1), r2: 8'(b2), s: sm, ov: ov};
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL period%0d: got an output period, want none pending", n);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              miscompares++;
              $display("FAIL period%0d: got l1=%0d l2=%0d r1=%0d r2=%0d settled=%b overlap=%b, want l1=%0d l2=%0d r1=%0d r2=%0d settled=%b overlap=%b",
                       n, act.l1, act.l2, act.r1, act.r2, act.s, act.ov,
                       e.l1, e.l2, e.r1, e.r2, e.s, e.ov);
            end
          end
          n++;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_pins("reset_state");
    reset = 1'b0;
    win(4'd0, 0, 0, 1);
    // ramp up to cruise
    win(4'd1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) win(4'd1, 10 * k, 10 * k, k == 6);
    // short idle glitch inside a period is ignored
    win(4'd1, 60, 60, 1);
    wait_pc(30);
    direction = 4'd0;
    wait_pc(40);
    direction = 4'd1;
    win(4'd1, 60, 60, 1);
    // full reversal: brake, dead-time, ramp in reverse
    win(4'd5, 60, 60, 0);
    for (int k = 1; k <= 5; k++) win(4'd5, 60 - 10 * k, 60 - 10 * k, 0);
    for (int k = 1; k <= 5; k++) win(4'd5, 0, 0, 0);
    for (int k = 1; k <= 6; k++) win(4'd5, -10 * k, -10 * k, k == 6);
    // stop ramps down without dead-time
    win(4'd12, -60, -60, 0);
    for (int k = 1; k <= 6; k++) win(4'd12, -60 + 10 * k, -60 + 10 * k, k == 6);
    // same sign restart ramps straight up
    win(4'd5, 0, 0, 0);
    for (int k = 1; k <= 6; k++) win(4'd5, -10 * k, -10 * k, k == 6);
    // reversal aborted mid-brake returns to RUN and ramps back
    win(4'd1, -60, -60, 0);
    win(4'd1, -50, -50, 0);
    win(4'd5, -40, -40, 0);
    win(4'd5, -50, -50, 0);
    win(4'd5, -60, -60, 1);
    // reset mid-period
    wait_pc(0);
    wait_pc(20);
    reset = 1'b1;
    @(negedge clk);
    check_pins("reset_mid_period");
    direction = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    // turn from rest: left ramps, right waits out dead-time
    win(4'd2, 0, 0, 0);
    for (int i = 1; i <= 9; i++)
      win(4'd2, i * 10 > 40 ? 40 : i * 10, i >= 6 ? -10 * (i - 5) : 0, i == 9);
    wait_pc(0);
    repeat (5) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d expected periods unconsumed, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
